// File: rtl/tlb_pkg.sv
// Shared types and constants for the multi-port MIPS32 TLB: request and
// exception codes, the entry layout and the unmapped segment decode constants.
package tlb_pkg;

    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
    localparam logic [31:0] PHYS_MASK  = 32'h1FFF_FFFF;

    typedef enum logic [2:0] {
        REQ_NONE  = 3'd0,
        REQ_TLBR  = 3'd1,
        REQ_TLBWI = 3'd2,
        REQ_TLBWR = 3'd3,
        REQ_TLBP  = 3'd4
    } tlb_req_t;

    typedef enum logic [2:0] {
        EXC_NONE      = 3'd0,
        EXC_REFILL_L  = 3'd1,
        EXC_REFILL_S  = 3'd2,
        EXC_INVALID_L = 3'd3,
        EXC_INVALID_S = 3'd4,
        EXC_MODIFIED  = 3'd5
    } tlb_exc_t;

    // Field order matches EntryLo[25:1], so a page is a straight slice of EntryLo.
    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic [18:0]        vpn2;
        logic [7:0]         asid;
        logic               g;
        tlb_page_t [1:0]    page;
    } tlb_entry_t;

    function automatic logic [31:0] page_to_lo(input tlb_page_t p, input logic g);
        return {6'b0, p, g};
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully associative VPN2/ASID compare across all TLB entries with a
// lowest-index-wins priority encoder.
module tlb_match
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]       i_present,
    input  logic [ENTRIES-1:0][18:0] i_tab_vpn2,
    input  logic [ENTRIES-1:0][7:0]  i_tab_asid,
    input  logic [ENTRIES-1:0]       i_tab_g,
    input  logic [18:0]              i_vpn2,
    input  logic [7:0]               i_asid,
    output logic                     o_hit,
    output logic [IDX_W-1:0]         o_idx
);

    logic [ENTRIES-1:0] w_match;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
            assign w_match[gi] = i_present[gi] && (i_tab_vpn2[gi] == i_vpn2) &&
                                 (i_tab_g[gi] || (i_tab_asid[gi] == i_asid));
        end
    endgenerate

    always_comb begin
        o_hit = |w_match;
        o_idx = '0;
        // Scan downwards so the last assignment is the lowest matching index.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_match[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/tlb_multiport.sv
// Joint MIPS32 TLB with PORTS registered lookup ports and one CP0 management
// port (TLBR/TLBWI/TLBWR/TLBP). Define TLB_WIRED_EN to add the CP0 Wired input.
module tlb_multiport
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int PORTS   = 2,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [PORTS-1:0]            lk_valid,
    input  logic [PORTS-1:0][31:0]      lk_vaddr,
    input  logic [PORTS-1:0]            lk_wr,
    input  logic [7:0]                  lk_asid,
    output logic [PORTS-1:0]            rs_valid,
    output logic [PORTS-1:0][31:0]      rs_paddr,
    output logic [PORTS-1:0]            rs_cached,
    output tlb_exc_t [PORTS-1:0]        rs_err,
    input  logic                        op_valid,
    input  tlb_req_t                    op,
    input  logic [IDX_W-1:0]            op_index,
    input  logic [31:0]                 op_entryhi,
    input  logic [31:0]                 op_entrylo0,
    input  logic [31:0]                 op_entrylo1,
    output logic                        op_done,
    output logic [31:0]                 rd_entryhi,
    output logic [31:0]                 rd_entrylo0,
    output logic [31:0]                 rd_entrylo1,
    output logic [31:0]                 pr_index,
`ifdef TLB_WIRED_EN
    input  logic [IDX_W-1:0]            wired,
`endif
    output logic [IDX_W-1:0]            random
);

    tlb_entry_t [ENTRIES-1:0]       r_entries;
    logic [ENTRIES-1:0]             r_present;
    logic [IDX_W-1:0]               r_random;
    logic                           r_op_done;
    logic [31:0]                    r_rd_entryhi, r_rd_entrylo0, r_rd_entrylo1, r_pr_index;

    logic [ENTRIES-1:0][18:0]       w_tab_vpn2;
    logic [ENTRIES-1:0][7:0]        w_tab_asid;
    logic [ENTRIES-1:0]             w_tab_g;
    logic                           w_wr_en, w_probe_hit;
    logic [IDX_W-1:0]               w_wr_idx, w_probe_idx, w_lower, w_random_next;
    tlb_entry_t                     w_wr_entry, w_rd_entry;
    logic                           w_unused;

    assign w_unused = ^{op_entryhi[12:8], op_entrylo0[31:26], op_entrylo1[31:26]};

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_tab
            assign w_tab_vpn2[gi] = r_entries[gi].vpn2;
            assign w_tab_asid[gi] = r_entries[gi].asid;
            assign w_tab_g[gi]    = r_entries[gi].g;
        end
    endgenerate

    assign w_wr_en    = op_valid && ((op == REQ_TLBWI) || (op == REQ_TLBWR));
    assign w_wr_idx   = (op == REQ_TLBWR) ? r_random : op_index;
    assign w_wr_entry = {op_entryhi[31:13], op_entryhi[7:0], op_entrylo0[0] & op_entrylo1[0],
                         op_entrylo1[25:1], op_entrylo0[25:1]};
    assign w_rd_entry = r_entries[op_index];

`ifdef TLB_WIRED_EN
    // Wired is IDX_W bits wide, so it can never exceed ENTRIES-1.
    assign w_lower = wired;
`else
    assign w_lower = '0;
`endif

    always_comb begin
        w_random_next = r_random - IDX_W'(1);
        if (w_wr_en || (r_random <= w_lower)) w_random_next = IDX_W'(ENTRIES - 1);
    end

    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_probe (
        .i_present (r_present),
        .i_tab_vpn2(w_tab_vpn2),
        .i_tab_asid(w_tab_asid),
        .i_tab_g   (w_tab_g),
        .i_vpn2    (op_entryhi[31:13]),
        .i_asid    (op_entryhi[7:0]),
        .o_hit     (w_probe_hit),
        .o_idx     (w_probe_idx)
    );

    // Entry payload carries no reset; only the present bits gate visibility.
    always_ff @(posedge clk) begin
        if (w_wr_en && resetn) r_entries[w_wr_idx] <= w_wr_entry;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_present     <= '0;
            r_random      <= IDX_W'(ENTRIES - 1);
            r_op_done     <= 1'b0;
            r_rd_entryhi  <= '0;
            r_rd_entrylo0 <= '0;
            r_rd_entrylo1 <= '0;
            r_pr_index    <= '0;
        end else begin
            r_op_done <= op_valid;
            r_random  <= w_random_next;
            if (w_wr_en) r_present[w_wr_idx] <= 1'b1;
            if (op_valid && (op == REQ_TLBR)) begin
                if (r_present[op_index]) begin
                    r_rd_entryhi  <= {w_rd_entry.vpn2, 5'b0, w_rd_entry.asid};
                    r_rd_entrylo0 <= page_to_lo(w_rd_entry.page[0], w_rd_entry.g);
                    r_rd_entrylo1 <= page_to_lo(w_rd_entry.page[1], w_rd_entry.g);
                end else begin
                    r_rd_entryhi  <= '0;
                    r_rd_entrylo0 <= '0;
                    r_rd_entrylo1 <= '0;
                end
            end
            if (op_valid && (op == REQ_TLBP)) begin
                r_pr_index <= w_probe_hit ? {{(32 - IDX_W){1'b0}}, w_probe_idx} : 32'h8000_0000;
            end
        end
    end

    assign op_done     = r_op_done;
    assign rd_entryhi  = r_rd_entryhi;
    assign rd_entrylo0 = r_rd_entrylo0;
    assign rd_entrylo1 = r_rd_entrylo1;
    assign pr_index    = r_pr_index;
    assign random      = r_random;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
            logic             w_hit, w_kseg0, w_kseg1, w_cached;
            logic [IDX_W-1:0] w_idx;
            tlb_page_t        w_page;
            logic [31:0]      w_paddr;
            tlb_exc_t         w_err;
            logic             r_valid, r_cached;
            logic [31:0]      r_paddr;
            tlb_exc_t         r_err;

            tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_match (
                .i_present (r_present),
                .i_tab_vpn2(w_tab_vpn2),
                .i_tab_asid(w_tab_asid),
                .i_tab_g   (w_tab_g),
                .i_vpn2    (lk_vaddr[gi][31:13]),
                .i_asid    (lk_asid),
                .o_hit     (w_hit),
                .o_idx     (w_idx)
            );

            assign w_kseg0 = lk_vaddr[gi][31:29] == KSEG0_BASE[31:29];
            assign w_kseg1 = lk_vaddr[gi][31:29] == KSEG1_BASE[31:29];
            assign w_page  = r_entries[w_idx].page[lk_vaddr[gi][12]];

            always_comb begin
                w_err    = EXC_NONE;
                w_paddr  = {w_page.pfn, lk_vaddr[gi][11:0]};
                w_cached = (w_page.c == 3'd3);
                if (w_kseg0 || w_kseg1) begin
                    w_paddr  = lk_vaddr[gi] & PHYS_MASK;
                    w_cached = w_kseg0;
                end else if (!w_hit) begin
                    w_err = lk_wr[gi] ? EXC_REFILL_S : EXC_REFILL_L;
                end else if (!w_page.v) begin
                    w_err = lk_wr[gi] ? EXC_INVALID_S : EXC_INVALID_L;
                end else if (lk_wr[gi] && !w_page.d) begin
                    w_err = EXC_MODIFIED;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_valid  <= 1'b0;
                    r_paddr  <= '0;
                    r_cached <= 1'b0;
                    r_err    <= EXC_NONE;
                end else begin
                    r_valid <= lk_valid[gi];
                    if (lk_valid[gi]) begin
                        r_paddr  <= w_paddr;
                        r_cached <= w_cached;
                        r_err    <= w_err;
                    end
                end
            end

            assign rs_valid[gi]  = r_valid;
            assign rs_paddr[gi]  = r_paddr;
            assign rs_cached[gi] = r_cached;
            assign rs_err[gi]    = r_err;
        end
    endgenerate

endmodule

// File: tb/tb_tlb_multiport.sv
// Directed, scoreboard-based bench for tlb_multiport (ENTRIES=32, PORTS=2);
// also builds with TLB_WIRED_EN, driving wired = 8.
module tb_tlb_multiport;
    import tlb_pkg::*;

    localparam int ENTRIES = 32;
    localparam int PORTS   = 2;
    localparam int IDX_W   = 5;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [PORTS-1:0]       lk_valid, lk_wr;
    logic [PORTS-1:0][31:0] lk_vaddr;
    logic [7:0]             lk_asid;
    logic [PORTS-1:0]       rs_valid, rs_cached;
    logic [PORTS-1:0][31:0] rs_paddr;
    tlb_exc_t [PORTS-1:0]   rs_err;
    logic                   op_valid;
    tlb_req_t               op;
    logic [IDX_W-1:0]       op_index;
    logic [31:0]            op_entryhi, op_entrylo0, op_entrylo1;
    logic                   op_done;
    logic [31:0]            rd_entryhi, rd_entrylo0, rd_entrylo1, pr_index;
    logic [IDX_W-1:0]       random;
`ifdef TLB_WIRED_EN
    logic [IDX_W-1:0]       wired = 5'd8;
    localparam int          LO_BOUND = 8;
`else
    localparam int          LO_BOUND = 0;
`endif

    tlb_multiport #(.ENTRIES(ENTRIES), .PORTS(PORTS), .IDX_W(IDX_W)) dut (
        .clk(clk), .resetn(resetn),
        .lk_valid(lk_valid), .lk_vaddr(lk_vaddr), .lk_wr(lk_wr), .lk_asid(lk_asid),
        .rs_valid(rs_valid), .rs_paddr(rs_paddr), .rs_cached(rs_cached), .rs_err(rs_err),
        .op_valid(op_valid), .op(op), .op_index(op_index), .op_entryhi(op_entryhi),
        .op_entrylo0(op_entrylo0), .op_entrylo1(op_entrylo1), .op_done(op_done),
        .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1),
        .pr_index(pr_index),
`ifdef TLB_WIRED_EN
        .wired(wired),
`endif
        .random(random)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          id;
        int          port;
        logic [31:0] pa;
        logic        c;
        tlb_exc_t    err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_id  = 0;
    int   exp_random;
    bit   exp_done;
    int   wr_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lk(input int p, input logic [31:0] va, input logic wr,
                      input logic [31:0] pa, input logic c, input tlb_exc_t err);
        lk_valid[p] = 1'b1;
        lk_vaddr[p] = va;
        lk_wr[p]    = wr;
        exp_q.push_back('{id: n_id, port: p, pa: pa, c: c, err: err});
        n_id++;
    endtask

    task automatic mg(input tlb_req_t o, input int idx, input logic [31:0] hi,
                      input logic [31:0] lo0, input logic [31:0] lo1);
        op_valid    = 1'b1;
        op          = o;
        op_index    = IDX_W'(idx);
        op_entryhi  = hi;
        op_entrylo0 = lo0;
        op_entrylo1 = lo1;
    endtask

    task automatic check_results();
        exp_t             e;
        logic [PORTS-1:0] seen;
        seen = '0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            seen[e.port] = 1'b1;
            $display("lookup %0d port %0d: err %0d paddr %h cached %0d", e.id, e.port,
                     rs_err[e.port], rs_paddr[e.port], rs_cached[e.port]);
            check($sformatf("lk%0d.valid", e.id), 32'(rs_valid[e.port]), 32'd1);
            check($sformatf("lk%0d.err", e.id), 32'(rs_err[e.port]), 32'(e.err));
            if (e.err == EXC_NONE) begin
                check($sformatf("lk%0d.paddr", e.id), rs_paddr[e.port], e.pa);
                check($sformatf("lk%0d.cached", e.id), 32'(rs_cached[e.port]), 32'(e.c));
            end
        end
        for (int p = 0; p < PORTS; p++) begin
            if (!seen[p]) check($sformatf("idle%0d.valid", p), 32'(rs_valid[p]), 32'd0);
        end
        check("op_done", 32'(op_done), 32'(exp_done));
        check("random", 32'(random), 32'(exp_random));
    endtask

    // One clock: the model of Random and op_done advances at the edge, results checked at the falling edge.
    task automatic step();
        @(posedge clk);
        exp_done = op_valid;
        if (op_valid && (op == REQ_TLBWI || op == REQ_TLBWR)) exp_random = ENTRIES - 1;
        else if (exp_random <= LO_BOUND) exp_random = ENTRIES - 1;
        else exp_random = exp_random - 1;
        @(negedge clk);
        lk_valid = '0;
        op_valid = 1'b0;
        check_results();
    endtask

    initial begin
        resetn = 1'b0;
        lk_valid = '0; lk_wr = '0; lk_vaddr = '0; lk_asid = '0;
        op_valid = 1'b0; op = REQ_NONE; op_index = '0;
        op_entryhi = '0; op_entrylo0 = '0; op_entrylo1 = '0;
        repeat (3) @(negedge clk);
        check("rst.rs_valid", 32'(rs_valid), 32'd0);
        check("rst.rs_paddr0", rs_paddr[0], 32'd0);
        check("rst.rs_err1", 32'(rs_err[1]), 32'(EXC_NONE));
        check("rst.op_done", 32'(op_done), 32'd0);
        check("rst.rd_entryhi", rd_entryhi, 32'd0);
        check("rst.pr_index", pr_index, 32'd0);
        resetn = 1'b1;
        exp_random = ENTRIES - 1;
        #1 check("rst.random", 32'(random), 32'(ENTRIES - 1));

        // Empty TLB: mapped lookups refill, unmapped segments bypass.
        lk(0, 32'h0000_1000, 1'b0, 32'h0, 1'b0, EXC_REFILL_L);
        lk(1, 32'h0000_1000, 1'b0, 32'h0, 1'b0, EXC_REFILL_L);
        step();
        lk(0, 32'h9FC0_0000, 1'b0, 32'h1FC0_0000, 1'b1, EXC_NONE);
        lk(1, 32'hBFC0_0000, 1'b1, 32'h1FC0_0000, 1'b0, EXC_NONE);
        step();

        // Write and lookup in the same cycle: the lookup sees the old contents.
        lk_asid = 8'h12;
        mg(REQ_TLBWI, 5, 32'h0040_2012, 32'h0000_48DE, 32'h0001_1592);
        lk(0, 32'h0040_2ABC, 1'b0, 32'h0, 1'b0, EXC_REFILL_L);
        step();
        lk(0, 32'h0040_2ABC, 1'b0, 32'h0012_3ABC, 1'b1, EXC_NONE);
        lk(1, 32'h0040_3004, 1'b1, 32'h0, 1'b0, EXC_MODIFIED);
        step();
        lk(1, 32'h0040_3004, 1'b0, 32'h0045_6004, 1'b0, EXC_NONE);
        step();
        step();
        check("hold.paddr0", rs_paddr[0], 32'h0012_3ABC);
        check("hold.paddr1", rs_paddr[1], 32'h0045_6004);

        lk_asid = 8'h13;
        lk(0, 32'h0040_2ABC, 1'b0, 32'h0, 1'b0, EXC_REFILL_L);
        lk(1, 32'h0040_2ABC, 1'b1, 32'h0, 1'b0, EXC_REFILL_S);
        step();

        // Global entry with an invalid odd page.
        mg(REQ_TLBWI, 6, 32'h0080_0055, 32'h0001_DDDF, 32'h0002_221D);
        step();
        lk_asid = 8'h99;
        lk(0, 32'h0080_1000, 1'b0, 32'h0, 1'b0, EXC_INVALID_L);
        lk(1, 32'h0080_1000, 1'b1, 32'h0, 1'b0, EXC_INVALID_S);
        step();
        lk(0, 32'h0080_0010, 1'b0, 32'h0077_7010, 1'b1, EXC_NONE);
        lk(1, 32'h0080_0010, 1'b1, 32'h0077_7010, 1'b1, EXC_NONE);
        step();

        // Probe and read-back.
        mg(REQ_TLBP, 0, 32'h0040_2012, 32'h0, 32'h0);
        step();
        check("tlbp.hit5", pr_index, 32'd5);
        mg(REQ_TLBP, 0, 32'h0040_2013, 32'h0, 32'h0);
        step();
        check("tlbp.miss", pr_index, 32'h8000_0000);
        mg(REQ_TLBP, 0, 32'h0080_0042, 32'h0, 32'h0);
        step();
        check("tlbp.global6", pr_index, 32'd6);
        mg(REQ_TLBR, 7, 32'h0, 32'h0, 32'h0);
        step();
        check("tlbr7.hi", rd_entryhi, 32'h0);
        check("tlbr7.lo0", rd_entrylo0, 32'h0);
        check("tlbr.pr_hold", pr_index, 32'd6);
        mg(REQ_TLBR, 5, 32'h0, 32'h0, 32'h0);
        step();
        check("tlbr5.hi", rd_entryhi, 32'h0040_2012);
        check("tlbr5.lo0", rd_entrylo0, 32'h0000_48DE);
        check("tlbr5.lo1", rd_entrylo1, 32'h0001_1592);
        mg(REQ_TLBR, 6, 32'h0, 32'h0, 32'h0);
        step();
        check("tlbr6.hi", rd_entryhi, 32'h0080_0055);
        check("tlbr6.lo0", rd_entrylo0, 32'h0001_DDDF);
        check("tlbr6.lo1", rd_entrylo1, 32'h0002_221D);
        mg(REQ_TLBP, 0, 32'h0040_2012, 32'h0, 32'h0);
        step();
        check("tlbp.rd_hold", rd_entryhi, 32'h0080_0055);

        // A duplicate at a lower index takes priority.
        mg(REQ_TLBWI, 2, 32'h0040_2012, 32'h0002_AA9E, 32'h0);
        step();
        lk_asid = 8'h12;
        lk(0, 32'h0040_2ABC, 1'b0, 32'h00AA_AABC, 1'b1, EXC_NONE);
        mg(REQ_TLBP, 0, 32'h0040_2012, 32'h0, 32'h0);
        step();
        check("tlbp.lowest", pr_index, 32'd2);

        // Random sequence including a wrap, then TLBWR at a known Random value.
        repeat (40) step();
        for (int i = 0; i < 64 && exp_random != 20; i++) step();
        check("random.target", 32'(random), 32'd20);
        wr_idx = exp_random;
        mg(REQ_TLBWR, 0, 32'h0100_0012, 32'h0002_EEDE, 32'h0);
        step();
        mg(REQ_TLBR, wr_idx, 32'h0, 32'h0, 32'h0);
        lk(0, 32'h0100_0123, 1'b0, 32'h00BB_B123, 1'b1, EXC_NONE);
        step();
        check("tlbwr.hi", rd_entryhi, 32'h0100_0012);
        check("tlbwr.lo0", rd_entrylo0, 32'h0002_EEDE);

        // Reset in the middle of a lookup and a write: both are dropped.
        mg(REQ_TLBWI, 9, 32'h0040_2012, 32'h0000_48DE, 32'h0);
        lk_valid[0] = 1'b1;
        lk_vaddr[0] = 32'h0040_2ABC;
        #2 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lk_valid = '0;
        op_valid = 1'b0;
        check("midrst.rs_valid", 32'(rs_valid), 32'd0);
        check("midrst.op_done", 32'(op_done), 32'd0);
        resetn = 1'b1;
        exp_random = ENTRIES - 1;
        #1 check("midrst.random", 32'(random), 32'(ENTRIES - 1));
        lk(0, 32'h0040_2ABC, 1'b0, 32'h0, 1'b0, EXC_REFILL_L);
        mg(REQ_TLBR, 5, 32'h0, 32'h0, 32'h0);
        step();
        check("midrst.tlbr5", rd_entryhi, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
